// File: rtl/norm_clz.sv
// norm_clz: iterative count-leading-zeros/ones with normalisation.
// Shifts the operand left one bit per cycle until its top bit is set, giving
// the leading-bit count and the left-normalised operand.
// Build option: define NORM_CLZ_CLO_EN to honour the 'ones' input (count
// leading ones); otherwise 'ones' is ignored and only clz is performed.
module norm_clz (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [31:0] d,
    input  logic        ones,
    output logic        busy,
    output logic        done,
    output logic [5:0]  count,
    output logic [31:0] norm
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e      state_q, state_d;
    logic [31:0] x_q, x_d;       // search word: operand, inverted for clo
    logic [31:0] y_q, y_d;       // operand being normalised
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] norm_q, norm_d;
    logic        ones_eff;

`ifdef NORM_CLZ_CLO_EN
    assign ones_eff = ones;
`else
    // Port kept for interface compatibility; clz only in this build.
    logic unused_ones;
    assign unused_ones = ones;
    assign ones_eff    = 1'b0;
`endif

    // Next-state and datapath decisions; everything holds unless updated.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        norm_d  = norm_q;
        case (state_q)
            StIdle, StFin: begin
                if (start) begin
                    x_d     = d ^ {32{ones_eff}};
                    y_d     = d;
                    cnt_d   = 6'd0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (x_q[31]) begin
                    count_d = cnt_q;
                    norm_d  = y_q;
                    state_d = StFin;
                end else if (x_q == 32'd0) begin
                    // No marker bit at all: full-width count, nothing to normalise.
                    count_d = 6'd32;
                    norm_d  = 32'd0;
                    state_d = StFin;
                end else begin
                    // x is non-zero here, so at most 31 shifts ever happen.
                    x_d   = {x_q[30:0], 1'b0};
                    y_d   = {y_q[30:0], 1'b0};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            cnt_q   <= 6'd0;
            count_q <= 6'd0;
            norm_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            norm_q  <= norm_d;
        end
    end

    // Status decoded straight from state; results come from held registers.
    always_comb begin
        busy  = (state_q == StRun);
        done  = (state_q == StFin);
        count = count_q;
        norm  = norm_q;
    end

endmodule

// File: doc/norm_clz.md
NORM_CLZ -- requirements
Module: norm_clz

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 clrn  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request pulse; sampled only when busy is 0.
REQ-004 d  input  32  operand, captured in the cycle start is accepted.
REQ-005 ones  input  1  selects the count: 1 = count leading ones (clo), 0 = count leading zeros (clz); captured with d.
REQ-006 busy  output  1  high while an operation is in progress.
REQ-007 done  output  1  one-cycle pulse when count and norm become valid.
REQ-008 count  output  6  leading-bit count, range 0..32.
REQ-009 norm  output  32  d shifted left by count, zero-filled.

Function
REQ-010 The block SHALL use three states: IDLE, RUN and FIN.
REQ-011 In IDLE or FIN with start=1, the block SHALL load x <= d ^ {32{ones}} and y <= d, clear cnt to 0, and enter RUN; busy SHALL go high on the next cycle.
REQ-012 In RUN, when x[31]=1, the block SHALL load count <= cnt, load norm <= y, and enter FIN.
REQ-013 In RUN, when x == 0, the block SHALL load count <= 32, load norm <= 0, and enter FIN.
REQ-014 In RUN otherwise, the block SHALL shift x <= x<<1 and y <= y<<1 (zero fill) and increment cnt by 1.
REQ-015 The cnt register SHALL be 6 bits wide and SHALL never exceed 31 while in RUN.
REQ-016 In FIN, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and the block SHALL return to IDLE unless start=1 (see REQ-011).
REQ-017 Latency from the start edge to done high SHALL be N+2 cycles for a leading count N < 32, and 2 cycles for count 32.
REQ-018 The start input SHALL be ignored while in RUN; the in-flight operation is not disturbed.
REQ-019 The count and norm outputs SHALL hold their last values from FIN through IDLE until the next FIN.
REQ-020 The count and norm outputs SHALL change only in the cycle that done rises.
REQ-021 An operation started in FIN SHALL behave identically to one started in IDLE (back-to-back issue).

Reset
REQ-022 clrn=0 SHALL, asynchronously, force state to IDLE and force busy=0, done=0, count=0, norm=0, x=0, y=0 and cnt=0.
REQ-023 A reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-024 After clrn deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-025 The macro NORM_CLZ_CLO_EN SHALL control leading-ones support.
REQ-026 With NORM_CLZ_CLO_EN defined, the ones input SHALL behave as specified above.
REQ-027 Without NORM_CLZ_CLO_EN, the ones input SHALL be ignored and treated as 0, so the block performs clz only; the port SHALL remain present.

Verification
REQ-028 Scenario: clz of d=32'h0000_0001 -> done 33 cycles after start, count=31, norm=32'h8000_0000.
REQ-029 Scenario: clz of d=32'h0000_0000 -> done 2 cycles after start, count=32, norm=0.
REQ-030 Scenario: clz of d=32'h8000_0000 -> done 2 cycles after start, count=0, norm=32'h8000_0000.
REQ-031 Scenario: clo with ones=1, d=32'hFFF0_1234 -> count=12, norm=32'h0123_4000 (with the macro); without the macro -> count=0, norm=32'hFFF0_1234.
REQ-032 Scenario: start pulsed mid-RUN, then start held during FIN with d=32'h00FF_0000 -> first result is unchanged, second result count=8 follows with no idle gap.
REQ-033 Scenario: clrn driven low during RUN -> busy=0, count=0 and norm=0 immediately, with no done pulse.
